// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one pipelined fpDiv core between NUM_REQ requesters.
//   Round-robin issues at most one divide per cycle. Each issued op is tagged
//   with its requester id, and the core result is steered back to that
//   requester's response channel when the tag leaves the tag pipe.
// Ports:
//   aclk, aresetn            clock (rising edge), async active-low reset
//   req_valid/req_ready      per-requester request handshake (ready is combinational)
//   req_a/req_b              dividend/divisor, requester i at [32*i+:32]
//   rsp_valid/rsp_ready      per-requester response handshake
//   rsp_data                 quotient, requester i at [32*i+:32]
//   div_value1/div_value2    registered operands to the fpDiv core
//   div_result               quotient from the fpDiv core
module fp_div_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIV_LATENCY = 8,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*32-1:0] rsp_data,
  output logic [31:0]           div_value1,
  output logic [31:0]           div_value2,
  input  logic [31:0]           div_result
);

  logic [NUM_REQ-1:0]              r_busy;
  logic [ID_W-1:0]                 r_rr_ptr;
  logic [NUM_REQ-1:0]              r_rsp_valid;
  logic [NUM_REQ*32-1:0]           r_rsp_data;
  logic [31:0]                     r_value1;
  logic [31:0]                     r_value2;
  // Stage 0 is written on the grant edge; the last stage lines up with div_result.
  logic [DIV_LATENCY:0]            r_tag_vld;
  logic [DIV_LATENCY:0][ID_W-1:0]  r_tag_id;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_next_ptr;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic               w_cap_vld;
  logic [ID_W-1:0]    w_cap_id;

  // Round-robin grant: scan downward so the candidate closest to r_rr_ptr wins.
  always_comb begin
    w_elig    = req_valid & ~r_busy;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    w_a       = '0;
    w_b       = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_idx = ID_W'((32'(r_rr_ptr) + 32'(k)) % NUM_REQ);
      if (w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
        w_a       = req_a[{w_idx, 5'd0} +: 32];
        w_b       = req_b[{w_idx, 5'd0} +: 32];
      end
    end
    req_ready  = w_gnt_vld ? (NUM_REQ'(1) << w_gnt_id) : '0;
    w_next_ptr = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    w_cap_vld  = r_tag_vld[DIV_LATENCY];
    w_cap_id   = r_tag_id[DIV_LATENCY];
  end

  // Operand register, pointer advance and tag pipe.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_value1  <= '0;
      r_value2  <= '0;
      r_rr_ptr  <= '0;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[DIV_LATENCY-1:0], w_gnt_vld};
      r_tag_id  <= {r_tag_id[DIV_LATENCY-1:0], w_gnt_id};
      if (w_gnt_vld) begin
        r_value1 <= w_a;
        r_value2 <= w_b;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  // Per-requester busy flag and response holding register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (req_ready[j]) begin
          r_busy[j] <= 1'b1;
        end else if (r_rsp_valid[j] && rsp_ready[j]) begin
          r_busy[j] <= 1'b0;
        end
        if (w_cap_vld && (w_cap_id == ID_W'(j))) begin
          r_rsp_valid[j]       <= 1'b1;
          r_rsp_data[32*j +: 32] <= div_result;
        end else if (r_rsp_valid[j] && rsp_ready[j]) begin
          r_rsp_valid[j] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign div_value1 = r_value1;
  assign div_value2 = r_value2;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: drives fp_div_arbiter against a stand-in fpDiv core and a
//   cycle-level behavioural model of the arbitration and response rules.
module tb_fp_div_arbiter;
  localparam int N = 4;
  localparam int L = 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [N*32-1:0]   rsp_data;
  logic [31:0]       div_value1;
  logic [31:0]       div_value2;
  logic [31:0]       div_result;

  fp_div_arbiter #(.NUM_REQ(N), .DIV_LATENCY(L)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .div_value1(div_value1), .div_value2(div_value2), .div_result(div_result)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Stand-in divider: exact quotients for the known operand pairs, a fixed scramble otherwise.
  function automatic logic [31:0] core_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3fc00000 && b == 32'h3fc00000) return 32'h3f800000;
    if (a == 32'hc0600000 && b == 32'h40200000) return 32'hbfb33333;
    if (a == 32'h40c00000 && b == 32'h40400000) return 32'h40000000;
    return {a[15:0], b[31:16]} ^ 32'ha5c30f1e;
  endfunction

  // fpDiv latency L: operands presented after edge E give the result after edge E+L.
  logic [31:0] core_pipe [L];
  initial for (int s = 0; s < L; s++) core_pipe[s] = 32'h0;
  always @(posedge aclk) begin
    for (int s = L - 1; s > 0; s--) core_pipe[s] <= core_pipe[s-1];
    core_pipe[0] <= core_f(div_value1, div_value2);
  end
  assign div_result = core_pipe[L-1];

  // Behavioural model state.
  bit          m_busy [N];
  bit          m_pend [N];
  bit          m_rv   [N];
  logic [31:0] m_rd   [N];
  logic [31:0] m_exp  [N];
  int          m_done [N];
  int          m_rr;
  logic [31:0] m_v1, m_v2;
  int          cyc;

  // Stimulus for the next cycle.
  logic [N-1:0] s_v, s_r;
  logic [31:0]  s_a [N];
  logic [31:0]  s_b [N];

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_busy[j] = 0; m_pend[j] = 0; m_rv[j] = 0; m_rd[j] = '0; m_exp[j] = '0; m_done[j] = 0;
    end
    m_rr = 0; m_v1 = '0; m_v2 = '0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (s_v[idx] && !m_busy[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    req_valid = s_v;
    rsp_ready = s_r;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = s_a[i];
      req_b[32*i +: 32] = s_b[i];
    end
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? N'(1) << g : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    for (int j = 0; j < N; j++) begin
      chk($sformatf("rsp_valid[%0d]", j), 64'(rsp_valid[j]), 64'(m_rv[j]));
      chk($sformatf("rsp_data[%0d]", j), 64'(rsp_data[32*j +: 32]), 64'(m_rd[j]));
    end
    chk("div_value1", 64'(div_value1), 64'(m_v1));
    chk("div_value2", 64'(div_value2), 64'(m_v2));
    // Advance the model to the state after the coming rising edge (edge number cyc+1).
    for (int j = 0; j < N; j++) begin
      if (m_rv[j] && s_r[j]) begin
        m_rv[j] = 0;
        m_busy[j] = 0;
      end
      if (m_pend[j] && (cyc + 1 == m_done[j])) begin
        m_rv[j] = 1;
        m_rd[j] = m_exp[j];
        m_pend[j] = 0;
      end
    end
    if (g >= 0) begin
      m_busy[g] = 1;
      m_pend[g] = 1;
      m_done[g] = cyc + 1 + L + 1;
      m_exp[g]  = core_f(s_a[g], s_b[g]);
      m_v1 = s_a[g];
      m_v2 = s_b[g];
      m_rr = (g + 1) % N;
    end
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    req_valid = '0;
    s_v       = '0;
    #1;
    chk("rst req_ready", 64'(req_ready), 64'h0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst rsp_data", 64'(rsp_data), 64'h0);
    chk("rst div_value1", 64'(div_value1), 64'h0);
    chk("rst div_value2", 64'(div_value2), 64'h0);
    model_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(5))
        0: begin s_a[i] = 32'h3fc00000; s_b[i] = 32'h3fc00000; end
        1: begin s_a[i] = 32'hc0600000; s_b[i] = 32'h40200000; end
        2: begin s_a[i] = 32'h40c00000; s_b[i] = 32'h40400000; end
        default: begin s_a[i] = $urandom; s_b[i] = $urandom; end
      endcase
    end
  endtask

  initial begin
    aresetn = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    s_v = '0; s_r = '1; cyc = 0;
    for (int i = 0; i < N; i++) begin s_a[i] = '0; s_b[i] = '0; end
    @(negedge aclk);
    do_reset();

    // Single op on requester 0, then on requester 1.
    s_a[0] = 32'h3fc00000; s_b[0] = 32'h3fc00000;
    s_v = 4'b0001; step(); s_v = '0; run(12);
    s_a[1] = 32'hc0600000; s_b[1] = 32'h40200000;
    s_v = 4'b0010; step(); s_v = '0; run(12);

    // All requesters valid from reset.
    do_reset();
    rand_ops();
    s_v = 4'b1111; s_r = '1; run(20);

    // Requester 2 stalls its response while the others keep issuing.
    s_r = 4'b1011; run(30);
    s_r = 4'b1111; run(15);
    s_v = '0; run(12);

    // Pointer at 2 with requesters 0 and 3 competing.
    do_reset();
    s_v = 4'b0010; step(); s_v = '0; run(12);
    rand_ops();
    s_v = 4'b1001; run(2); s_v = '0; run(12);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      s_v = N'($urandom);
      s_r = N'($urandom) | N'($urandom);
      step();
    end
    s_v = '0; s_r = '1; run(15);

    // Reset with ops in flight, then a fresh op.
    rand_ops();
    s_v = 4'b0111; run(3);
    do_reset();
    s_v = '0; run(12);
    s_a[3] = 32'h40c00000; s_b[3] = 32'h40400000;
    s_v = 4'b1000; step(); s_v = '0; run(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
